// File: rtl/fifo_wptr_full.sv
// -----------------------------------------------------------------------------
// fifo_wptr_full
//
// Purpose:
//   Write-domain half of an asynchronous FIFO. It keeps the binary write
//   pointer that addresses the dual-port memory and publishes a registered
//   Gray-coded copy for the read domain. The read domain's Gray pointer is
//   brought into wr_clk through a flop chain. From it the block derives full,
//   almost_full and the write-side fill level.
//
// Parameters:
//   Addr_Width         - memory address bits (depth = 2**Addr_Width, >= 2)
//   Sync_Stages        - wr_clk flops in the read-pointer synchronizer (2 or 3)
//   Almost_Full_Thresh - almost_full asserts when free slots <= this value
//
// Ports:
//   wr_clk       in   write-domain clock
//   wr_rst       in   asynchronous, active-high reset
//   wr_en        in   write request from the producer
//   rd_gray_ptr  in   [Addr_Width:0] read pointer, Gray, registered at source
//   wr_addr      out  [Addr_Width:0] binary write pointer incl. wrap bit
//   wr_gray_ptr  out  [Addr_Width:0] registered Gray write pointer
//   full         out  FIFO full (also feeds the memory's full input)
//   almost_full  out  free slots <= Almost_Full_Thresh
//   wr_level     out  [Addr_Width:0] occupancy seen from the write side
//   overflow     out  sticky write-while-full flag (only when the macro
//                     FIFO_WR_OVERFLOW_EN is defined)
//
// Optional feature macro: FIFO_WR_OVERFLOW_EN
//   Defined   : the overflow port exists and latches any write attempted
//               while full until wr_rst.
//   Undefined : no overflow port; writes while full are silently dropped.
//
// Notes:
//   full, almost_full and wr_level are computed from a read pointer that is
//   Sync_Stages cycles old. That is deliberately pessimistic: the write side
//   can over-report occupancy but never under-report it.
// -----------------------------------------------------------------------------
module fifo_wptr_full #(
  parameter int Addr_Width         = 8,
  parameter int Sync_Stages        = 2,
  parameter int Almost_Full_Thresh = 4
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  wr_en,
  input  logic [Addr_Width:0]   rd_gray_ptr,
  output logic [Addr_Width:0]   wr_addr,
  output logic [Addr_Width:0]   wr_gray_ptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [Addr_Width:0]   wr_level
`ifdef FIFO_WR_OVERFLOW_EN
  ,
  output logic                  overflow
`endif
);

  // Pointer width: address bits plus one wrap bit.
  localparam int PW = Addr_Width + 1;

  // Depth and threshold, one bit wider than a pointer so that the
  // free-slot subtraction below cannot wrap for legal levels.
  localparam logic [PW:0] C_DEPTH  = {1'b0, 1'b1, {Addr_Width{1'b0}}};
  localparam logic [PW:0] C_THRESH = (PW + 1)'(Almost_Full_Thresh);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wgray;
  logic          r_full;
  logic          r_almost_full;
  logic [PW-1:0] r_level;
  logic [PW-1:0] r_rq_sync [Sync_Stages];

  // ---------------------------------------------------------------------------
  // Combinational next-state values
  // ---------------------------------------------------------------------------
  logic          w_push;
  logic [PW-1:0] w_rq_sync;
  logic [PW-1:0] w_rbin_sync;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_full_pattern;
  logic          w_full_next;
  logic [PW-1:0] w_level_next;
  logic [PW:0]   w_free_next;
  logic          w_almost_full_next;

  // ---------------------------------------------------------------------------
  // Read-pointer synchronizer: a plain flop chain. Only the last stage is
  // consumed; the earlier stages exist to let metastability settle.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < Sync_Stages; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge wr_clk or posedge wr_rst) begin
          if (wr_rst) begin
            r_rq_sync[gi] <= '0;
          end else begin
            r_rq_sync[gi] <= rd_gray_ptr;
          end
        end
      end else begin : g_next
        always_ff @(posedge wr_clk or posedge wr_rst) begin
          if (wr_rst) begin
            r_rq_sync[gi] <= '0;
          end else begin
            r_rq_sync[gi] <= r_rq_sync[gi-1];
          end
        end
      end
    end
  endgenerate

  assign w_rq_sync = r_rq_sync[Sync_Stages-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits from the
  // MSB down to and including that bit position.
  generate
    for (genvar gi = 0; gi < PW; gi++) begin : g_g2b
      assign w_rbin_sync[gi] = ^w_rq_sync[PW-1:gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Write pointer advance
  // ---------------------------------------------------------------------------
  // A write presented while full is simply not a push; pointers hold.
  assign w_push       = wr_en & ~r_full;
  assign w_wbin_next  = r_wbin + {{Addr_Width{1'b0}}, w_push};
  assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

  // Full when the next write pointer is exactly one lap ahead of the read
  // pointer. In Gray code one lap ahead means the top two bits inverted and
  // the rest equal. Using the *next* pointer makes full assert on the same
  // edge as the write that fills the last slot.
  assign w_full_pattern = {~w_rq_sync[PW-1:PW-2], w_rq_sync[PW-3:0]};
  assign w_full_next    = (w_wgray_next == w_full_pattern);

  // Level uses modulo arithmetic on the wrap-bit pointers, so a difference of
  // exactly 2**Addr_Width (full) is representable.
  assign w_level_next       = w_wbin_next - w_rbin_sync;
  assign w_free_next        = C_DEPTH - {1'b0, w_level_next};
  assign w_almost_full_next = (w_free_next <= C_THRESH);

  // ---------------------------------------------------------------------------
  // Pointer and flag registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_wbin        <= '0;
      r_wgray       <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_level       <= '0;
    end else begin
      r_wbin        <= w_wbin_next;
      r_wgray       <= w_wgray_next;
      r_full        <= w_full_next;
      r_almost_full <= w_almost_full_next;
      r_level       <= w_level_next;
    end
  end

`ifdef FIFO_WR_OVERFLOW_EN
  // Sticky record of any write attempted while full; only reset clears it.
  logic r_overflow;

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_overflow <= 1'b0;
    end else if (wr_en & r_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The memory samples wr_addr together with the push, so data lands at the
  // pre-increment address.
  assign wr_addr     = r_wbin;
  assign wr_gray_ptr = r_wgray;
  assign full        = r_full;
  assign almost_full = r_almost_full;
  assign wr_level    = r_level;

endmodule
